// File: rtl/bit_serializer.sv
// bit_serializer: buffers WIDTH-bit words in a small FIFO and shifts them out
// MSB-first, one bit per clock, with no gap between consecutive words.
module bit_serializer #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DEPTH    = 4,
    parameter logic        IDLE_BIT = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             out,
    output logic             out_valid,
    output logic             last,
    output logic             busy
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam int unsigned BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;

    state_t           r_state;
    logic [WIDTH-1:0] r_sr;
    logic [BW-1:0]    r_bc;
    logic             r_out;
    logic             r_out_valid;
    logic             r_last;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic [WIDTH-1:0] w_head;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == CW'(0));
    assign w_push  = din_valid && !w_full;
    // A pop only happens when a word is already stored, so a word written
    // at this edge is never loaded at the same edge.
    assign w_pop   = !w_empty && ((r_state == S_IDLE) || (r_bc == BW'(0)));
    assign w_head  = r_mem[r_rptr];

    assign din_ready = !w_full;
    assign busy      = (r_state == S_SHIFT) || !w_empty;
    assign out       = r_out;
    assign out_valid = r_out_valid;
    assign last      = r_last;

    // Word storage; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (!reset && w_push) begin
            r_mem[r_wptr] <= din;
        end
    end

    // FIFO pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= AW'(0);
            r_rptr  <= AW'(0);
            r_count <= CW'(0);
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Shifter FSM with registered serial outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_sr        <= WIDTH'(0);
            r_bc        <= BW'(0);
            r_out       <= IDLE_BIT;
            r_out_valid <= 1'b0;
            r_last      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_state     <= S_SHIFT;
                        r_sr        <= w_head;
                        r_bc        <= BW'(WIDTH - 1);
                        r_out       <= w_head[WIDTH-1];
                        r_out_valid <= 1'b1;
                        r_last      <= 1'b0;
                    end else begin
                        r_out       <= IDLE_BIT;
                        r_out_valid <= 1'b0;
                        r_last      <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    if (r_bc != BW'(0)) begin
                        r_sr        <= r_sr << 1;
                        r_out       <= r_sr[WIDTH-2];
                        r_bc        <= r_bc - BW'(1);
                        r_last      <= (r_bc == BW'(1));
                        r_out_valid <= 1'b1;
                    end else if (w_pop) begin
                        // Gapless reload straight after the previous LSB.
                        r_sr        <= w_head;
                        r_bc        <= BW'(WIDTH - 1);
                        r_out       <= w_head[WIDTH-1];
                        r_out_valid <= 1'b1;
                        r_last      <= 1'b0;
                    end else begin
                        r_state     <= S_IDLE;
                        r_out       <= IDLE_BIT;
                        r_out_valid <= 1'b0;
                        r_last      <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_out       <= IDLE_BIT;
                    r_out_valid <= 1'b0;
                    r_last      <= 1'b0;
                end
            endcase
        end
    end

endmodule
